// File: rtl/seq_divider_16by8_if.sv
// ---------------------------------------------------------------------------
// seq_divider_16by8_if
// Handshake/operand bundle for the sequential 16/8 divider.
//   start       : request from the master, sampled by the divider when idle
//   dividend    : 16-bit numerator, captured on an accepted start
//   divisor     : 8-bit denominator, captured on an accepted start
//   busy        : division in progress
//   done        : one-cycle pulse, results valid
//   quotient    : 16-bit registered quotient
//   remainder   : 8-bit registered remainder
//   div_by_zero : set when the completed operation had divisor == 0
// ---------------------------------------------------------------------------
interface seq_divider_16by8_if;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider_16by8.sv
// ---------------------------------------------------------------------------
// seq_divider_16by8
// Restoring divider: 16-bit dividend / 8-bit divisor -> 16-bit quotient and
// 8-bit remainder, one quotient bit per clock, MSB first.
// Ports:
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : seq_divider_16by8_if.slave (start/busy/done handshake, operands,
//         results and divide-by-zero flag)
// busy and done are registered from the FSM state, so they trail the state
// by one cycle: a normal divide shows done 17 cycles after the accepting
// edge, a divide-by-zero shows done 1 cycle after it.
// ---------------------------------------------------------------------------
module seq_divider_16by8 (
  input  logic                      clk,
  input  logic                      rst,
  seq_divider_16by8_if.slave        bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_reg;
  logic [15:0] dividend_shift_reg;
  logic [7:0]  divisor_reg;
  logic [7:0]  partial_reg;
  logic [15:0] quot_work_reg;
  logic [3:0]  count_reg;
  logic        busy_reg;
  logic        done_reg;
  logic [15:0] quotient_reg;
  logic [7:0]  remainder_reg;
  logic        div_by_zero_reg;

  // One restoring step. The shifted value r9 needs 9 bits (up to
  // 2*divisor-1), but after the conditional subtract it is always below the
  // divisor, so only 8 bits of partial remainder need to be stored.
  logic [8:0]  r9;
  logic        qbit;
  logic [7:0]  partial_next;
  logic [15:0] quot_next;

  always_comb begin
    r9           = {partial_reg, dividend_shift_reg[15]};
    qbit         = (r9 >= {1'b0, divisor_reg});
    partial_next = qbit ? 8'(r9 - {1'b0, divisor_reg}) : r9[7:0];
    quot_next    = {quot_work_reg[14:0], qbit};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg          <= IDLE;
      dividend_shift_reg <= '0;
      divisor_reg        <= '0;
      partial_reg        <= '0;
      quot_work_reg      <= '0;
      count_reg          <= '0;
      busy_reg           <= 1'b0;
      done_reg           <= 1'b0;
      quotient_reg       <= '0;
      remainder_reg      <= '0;
      div_by_zero_reg    <= 1'b0;
    end else begin
      busy_reg <= (state_reg == CALC);
      done_reg <= (state_reg == DONE);

      case (state_reg)
        // DONE accepts a new start exactly like IDLE for back-to-back use.
        IDLE, DONE: begin
          if (bus.start) begin
            if (bus.divisor != 8'd0) begin
              dividend_shift_reg <= bus.dividend;
              divisor_reg        <= bus.divisor;
              partial_reg        <= '0;
              quot_work_reg      <= '0;
              count_reg          <= '0;
              state_reg          <= CALC;
            end else begin
              quotient_reg       <= 16'hFFFF;
              remainder_reg      <= bus.dividend[7:0];
              div_by_zero_reg    <= 1'b1;
              state_reg          <= DONE;
            end
          end else begin
            state_reg <= IDLE;
          end
        end

        CALC: begin
          partial_reg        <= partial_next;
          quot_work_reg      <= quot_next;
          dividend_shift_reg <= {dividend_shift_reg[14:0], 1'b0};
          count_reg          <= count_reg + 4'd1;
          if (count_reg == 4'd15) begin
            quotient_reg    <= quot_next;
            remainder_reg   <= partial_next;
            div_by_zero_reg <= 1'b0;
            state_reg       <= DONE;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy        = busy_reg;
  assign bus.done        = done_reg;
  assign bus.quotient    = quotient_reg;
  assign bus.remainder   = remainder_reg;
  assign bus.div_by_zero = div_by_zero_reg;

endmodule

// File: tb/tb_seq_divider_16by8.sv
// ---------------------------------------------------------------------------
// tb_seq_divider_16by8
// Self-checking bench for seq_divider_16by8: directed cases, back-to-back
// operation, mid-division reset and randomized operands, compared against
// plain integer division.
// ---------------------------------------------------------------------------
module tb_seq_divider_16by8;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  seq_divider_16by8_if dif ();

  seq_divider_16by8 dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Reference model: plain integer division with the divide-by-zero rule.
  function automatic logic [15:0] ref_q(input logic [15:0] dd, input logic [7:0] dv);
    return (dv == 8'd0) ? 16'hFFFF : 16'(dd / dv);
  endfunction

  function automatic logic [7:0] ref_r(input logic [15:0] dd, input logic [7:0] dv);
    return (dv == 8'd0) ? dd[7:0] : 8'(dd % dv);
  endfunction

  // Wait for done, starting lat_start edges after the accepting edge. Checks
  // latency, busy-cycle count and the results. Optionally pokes a start
  // request during the division at cycle poke_at (must be ignored).
  task automatic wait_done(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                           input int lat_start, input int poke_at);
    int lat;
    int busy_cnt;
    int exp_lat;
    lat      = lat_start;
    busy_cnt = (lat_start > 0) ? lat_start : 0;
    exp_lat  = (dv == 8'd0) ? 1 : 17;
    while (dif.done !== 1'b1 && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (dif.busy === 1'b1) busy_cnt++;
      if (lat == poke_at) begin
        dif.start    = 1'b1;
        dif.dividend = 16'd50;
        dif.divisor  = 8'd5;
      end else if (lat == poke_at + 1) begin
        dif.start    = 1'b0;
      end
    end
    $display("op %s: %0d / %0d -> q=%0d r=%0d dbz=%0b lat=%0d", tag, dd, dv,
             dif.quotient, dif.remainder, dif.div_by_zero, lat);
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, busy_cnt, (dv == 8'd0) ? 0 : 16);
    check({tag, "_quotient"}, dif.quotient, ref_q(dd, dv));
    check({tag, "_remainder"}, dif.remainder, ref_r(dd, dv));
    check({tag, "_dbz"}, dif.div_by_zero, (dv == 8'd0) ? 1 : 0);
  endtask

  task automatic check_pulse_end(input string tag);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, dif.done, 0);
  endtask

  // Single isolated operation from IDLE; operands are scrambled right after
  // the accepting edge to show they are captured.
  task automatic run_op(input string tag, input logic [15:0] dd, input logic [7:0] dv,
                        input int poke_at);
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = dd;
    dif.divisor  = dv;
    @(posedge clk);
    #1;
    dif.start    = 1'b0;
    dif.dividend = 16'($urandom);
    dif.divisor  = 8'($urandom);
    wait_done(tag, dd, dv, 0, poke_at);
    check_pulse_end(tag);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int done_seen;
    logic [15:0] dd;
    logic [7:0]  dv;
    n_checks     = 0;
    n_errors     = 0;
    rst          = 1'b1;
    dif.start    = 1'b0;
    dif.dividend = '0;
    dif.divisor  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_busy", dif.busy, 0);
    check("reset_done", dif.done, 0);
    check("reset_quotient", dif.quotient, 0);
    check("reset_remainder", dif.remainder, 0);
    check("reset_dbz", dif.div_by_zero, 0);

    // Directed cases and extremes.
    run_op("basic", 16'd1000, 8'd7, -1);
    run_op("ffff_by_1", 16'hFFFF, 8'd1, -1);
    run_op("ffff_by_ff", 16'hFFFF, 8'hFF, -1);
    run_op("small_by_big", 16'd5, 8'd200, -1);
    run_op("div_zero", 16'd100, 8'd0, -1);

    // Start during CALC is ignored, then the poked operands run normally.
    run_op("ignore_start", 16'd1000, 8'd7, 5);
    run_op("after_ignore", 16'd50, 8'd5, -1);

    // Reset during CALC aborts without a done pulse.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 16'd1000;
    dif.divisor  = 8'd7;
    @(posedge clk);
    #1;
    dif.start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", dif.busy, 0);
    check("abort_quotient", dif.quotient, 0);
    check("abort_remainder", dif.remainder, 0);
    done_seen = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (dif.done === 1'b1) done_seen++;
    end
    check("abort_no_done", done_seen, 0);
    run_op("after_abort", 16'd81, 8'd9, -1);

    // Back-to-back with start held high: 100/0, 1000/7, 65535/255.
    @(negedge clk);
    dif.start    = 1'b1;
    dif.dividend = 16'd100;
    dif.divisor  = 8'd0;
    @(posedge clk);
    #1;
    dif.dividend = 16'd1000;
    dif.divisor  = 8'd7;
    wait_done("b2b_zero", 16'd100, 8'd0, 0, -1);
    dif.dividend = 16'd65535;
    dif.divisor  = 8'd255;
    check_pulse_end("b2b_zero");
    wait_done("b2b_1000_7", 16'd1000, 8'd7, 1, -1);
    dif.start = 1'b0;
    check_pulse_end("b2b_1000_7");
    wait_done("b2b_ffff_ff", 16'd65535, 8'd255, 1, -1);
    check_pulse_end("b2b_ffff_ff");
    repeat (2) @(posedge clk);
    #1;

    // Randomized operands, with some zero and small divisors.
    for (int i = 0; i < 24; i++) begin
      dd = 16'($urandom);
      case ($urandom_range(0, 5))
        0:       dv = 8'd0;
        1:       dv = 8'($urandom_range(1, 3));
        default: dv = 8'($urandom);
      endcase
      run_op($sformatf("rand%0d", i), dd, dv, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
